// File: rtl/param_int_sqrt_finder_pkg.sv
// Shared types for the integer square root finder.
// State encoding and the even-width check used by parametrised arithmetic units.
package param_int_sqrt_finder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic bit width_ok(input int w);
    return (w >= 2) && (w % 2 == 0);
  endfunction

endpackage

// File: rtl/param_int_sqrt_finder_datapath.sv
// Restoring digit-by-digit sqrt datapath: opnd/part/root regs, compare-subtract.
// Ports: clk, clr, en_ld/en_step/en_out strobes, a in; sqrt/rem held results out.
module param_int_sqrt_finder_datapath
  import param_int_sqrt_finder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en_ld,
  input  logic               en_step,
  input  logic               en_out,
  input  logic [WIDTH-1:0]   a,
  output logic [WIDTH/2-1:0] sqrt,
  output logic [WIDTH/2:0]   rem
);

  localparam int N  = WIDTH / 2;
  localparam int PW = N + 2;

  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [PW-1:0]    part_q, part_d;
  logic [N-1:0]     root_q, root_d;
  logic [N-1:0]     sqrt_q, sqrt_d;
  logic [N:0]       rem_q, rem_d;

  logic [PW-1:0]    part_sh;
  logic [PW-1:0]    trial;
  logic [PW-1:0]    part_nx;
  logic [N-1:0]     root_nx;
  logic             take;

  always_comb begin
    part_sh = (part_q << 2) | PW'(opnd_q[WIDTH-1 -: 2]);
    trial   = {root_q, 2'b01};
    take    = (part_sh >= trial);
    part_nx = take ? (part_sh - trial) : part_sh;
    root_nx = root_q << 1;
    root_nx[0] = take;

    opnd_d = opnd_q;
    part_d = part_q;
    root_d = root_q;
    sqrt_d = sqrt_q;
    rem_d  = rem_q;

    if (en_ld) begin
      opnd_d = a;
      part_d = '0;
      root_d = '0;
    end else if (en_step) begin
      opnd_d = opnd_q << 2;
      part_d = part_nx;
      root_d = root_nx;
    end

    // Final step result goes straight to the outputs on the same edge.
    if (en_out) begin
      sqrt_d = root_nx;
      rem_d  = part_nx[N:0];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      opnd_q <= '0;
      part_q <= '0;
      root_q <= '0;
      sqrt_q <= '0;
      rem_q  <= '0;
    end else begin
      opnd_q <= opnd_d;
      part_q <= part_d;
      root_q <= root_d;
      sqrt_q <= sqrt_d;
      rem_q  <= rem_d;
    end
  end

  assign sqrt = sqrt_q;
  assign rem  = rem_q;

endmodule

// File: rtl/param_int_sqrt_finder.sv
// Parametrised unsigned integer sqrt with busy/done handshake, 1 root bit/clock.
// Ports: clk, clr (sync reset), start, a in; busy, done, sqrt, rem out.
module param_int_sqrt_finder
  import param_int_sqrt_finder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] sqrt,
  output logic [WIDTH/2:0]   rem
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("param_int_sqrt_finder: WIDTH must be even and >= 2");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_ld;
  logic          en_step;
  logic          en_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_ld   = 1'b0;
    en_step = 1'b0;
    en_out  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = CW'(N - 1);
          en_ld   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        en_step = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          en_out  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_DONE);

  param_int_sqrt_finder_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .clr    (clr),
    .en_ld  (en_ld),
    .en_step(en_step),
    .en_out (en_out),
    .a      (a),
    .sqrt   (sqrt),
    .rem    (rem)
  );

endmodule
